// File: rtl/mem_request_sequencer.sv
// mem_request_sequencer
//   Request front-end for the memory controller. Byte load/store requests from
//   the core are buffered in a small FIFO. They are then issued one at a time
//   on the controller strobes, and each request gets exactly one response pulse.
//
// Ports
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready    core request handshake
//   req_we/addr/wdata      request payload (1 = store)
//   rsp_valid/we/rdata/err one-cycle response pulse, no back-pressure
//   seq_busy               sequencer has work (FSM active or FIFO non-empty)
//   mc_wr_req/mc_rd_req    controller strobes, held HOLD_CYCLES cycles
//   mc_addr/mc_data_in     controller address / write data (0 when idle)
//   mc_data_out            controller read data, captured in WAIT
//   mc_busy/full/empty     controller status
//
// Handshake: a request transfers on every rising clk edge where
// req_valid && req_ready. req_ready depends only on the FIFO occupancy, so a
// full FIFO never accepts, even if it pops in the same cycle. The core must
// hold the payload stable while req_valid is high and not yet accepted.
module mem_request_sequencer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [10:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic        rsp_we,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        seq_busy,
  output logic        mc_wr_req,
  output logic        mc_rd_req,
  output logic [10:0] mc_addr,
  output logic [7:0]  mc_data_in,
  input  logic [7:0]  mc_data_out,
  input  logic        mc_busy,
  input  logic        mc_full,
  input  logic        mc_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  state_t        state_next;

  // FIFO entry layout: {we, addr[10:0], wdata[7:0]}
  logic [19:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [19:0]   head;
  logic          push;
  logic          pop;

  logic          cmd_we;
  logic [10:0]   cmd_addr;
  logic [7:0]    cmd_wdata;
  logic [7:0]    rdata_q;
  logic          err_q;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tmo_cnt;

  logic          refuse;
  logic          finish_ok;
  logic          finish_tmo;
  logic          cmd_active;

  // ---------------- request FIFO ----------------
  assign req_ready = (count != FULL_COUNT);
  assign push      = req_valid && req_ready;
  assign head      = fifo_mem[rd_ptr];

  // Storage needs no reset: entries are only read when count says they exist.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_we, req_addr, req_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- sequencing FSM ----------------
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    refuse     = 1'b0;
    finish_ok  = 1'b0;
    finish_tmo = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          // A store into a full controller or a load from an empty one is
          // answered with an error without ever touching the controller.
          refuse     = head[19] ? mc_full : mc_empty;
          state_next = refuse ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (hold_cnt == HOLD_LAST) state_next = WAIT;
      end
      WAIT: begin
        if (!mc_busy) begin
          finish_ok  = 1'b1;
          state_next = RESP;
        end else if (tmo_cnt == TMO_LIMIT) begin
          // TIMEOUT busy cycles already counted; this is the one past the limit.
          finish_tmo = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      hold_cnt  <= '0;
      tmo_cnt   <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        {cmd_we, cmd_addr, cmd_wdata} <= head;
        err_q   <= refuse;
        rdata_q <= '0;
      end
      if (state == ISSUE) hold_cnt <= hold_cnt + HW'(1);
      else                hold_cnt <= '0;
      if (state == WAIT) begin
        if (mc_busy && !finish_tmo) tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end
      if (finish_ok) begin
        err_q   <= 1'b0;
        rdata_q <= cmd_we ? 8'h00 : mc_data_out;
      end
      if (finish_tmo) begin
        err_q   <= 1'b1;
        rdata_q <= 8'h00;
      end
    end
  end

  // ---------------- outputs ----------------
  // Strobes decode straight from the state register so an asynchronous reset
  // drops them immediately.
  assign cmd_active = (state == ISSUE) || (state == WAIT);
  assign mc_wr_req  = (state == ISSUE) && cmd_we;
  assign mc_rd_req  = (state == ISSUE) && !cmd_we;
  assign mc_addr    = cmd_active ? cmd_addr : 11'h000;
  assign mc_data_in = cmd_active ? cmd_wdata : 8'h00;

  assign rsp_valid  = (state == RESP);
  assign rsp_we     = rsp_valid && cmd_we;
  assign rsp_rdata  = rsp_valid ? rdata_q : 8'h00;
  assign rsp_err    = rsp_valid && err_q;
  assign seq_busy   = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_mem_request_sequencer.sv
// tb_mem_request_sequencer
//   Self-checking bench for mem_request_sequencer. Table-driven single requests,
//   followed by hand-written busy-stretch, timeout, FIFO full/wrap and
//   mid-ISSUE reset sequences. It has a scoreboard queue of expected responses
//   and a small memory-controller model.
module tb_mem_request_sequencer;

  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [10:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_we;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        seq_busy;
  logic        mc_wr_req;
  logic        mc_rd_req;
  logic [10:0] mc_addr;
  logic [7:0]  mc_data_in;
  logic [7:0]  mc_data_out;
  logic        mc_busy = 1'b0;
  logic        mc_full = 1'b0;
  logic        mc_empty = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int rsp_seen = 0;

  mem_request_sequencer #(.DEPTH(4), .HOLD_CYCLES(HOLD), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .seq_busy(seq_busy),
    .mc_wr_req(mc_wr_req), .mc_rd_req(mc_rd_req), .mc_addr(mc_addr),
    .mc_data_in(mc_data_in), .mc_data_out(mc_data_out),
    .mc_busy(mc_busy), .mc_full(mc_full), .mc_empty(mc_empty)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- controller model ----------------
  logic [7:0] ctrl_mem [2048];
  assign mc_data_out = ctrl_mem[mc_addr];
  always @(posedge clk) begin
    if (!rst && mc_wr_req) ctrl_mem[mc_addr] = mc_data_in;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        we;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        err;
    logic        strobe;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  logic strobe_prev = 1'b0;
  logic strobed_cur = 1'b0;
  int   run_len = 0;

  always @(negedge clk) begin
    exp_t e;
    logic s;
    if (rst) begin
      strobe_prev = 1'b0;
      strobed_cur = 1'b0;
      run_len = 0;
      exp_q.delete();
    end else begin
      s = mc_wr_req || mc_rd_req;
      if (s && !strobe_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(1), 32'(0));
        end else begin
          check("strobe_expected", 32'(1), 32'(exp_q[0].strobe));
          check("strobe_wr", 32'(mc_wr_req), 32'(exp_q[0].we));
          check("strobe_rd", 32'(mc_rd_req), 32'(!exp_q[0].we));
          check("strobe_addr", 32'(mc_addr), 32'(exp_q[0].addr));
          if (exp_q[0].we) check("strobe_data", 32'(mc_data_in), 32'(exp_q[0].wdata));
        end
        strobed_cur = 1'b1;
      end
      if (s) begin
        run_len++;
      end else if (strobe_prev) begin
        check("strobe_len", 32'(run_len), 32'(HOLD));
        run_len = 0;
      end
      strobe_prev = s;

      if (rsp_valid) begin
        rsp_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_we", 32'(rsp_we), 32'(e.we));
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_strobed", 32'(strobed_cur), 32'(e.strobe));
          check("resp_addr_zero", 32'(mc_addr), 32'(0));
          check("resp_data_zero", 32'(mc_data_in), 32'(0));
          if (e.lat >= 0) check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
        strobed_cur = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic we, input logic [10:0] addr, input logic [7:0] wdata,
                      input logic [7:0] erd, input logic eerr, input logic estr,
                      input int lat, output int acc);
    int w;
    exp_t e;
    w = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_bound", 32'(w < 100), 32'(1));
    acc = cyc;
    e = '{we, addr, wdata, erd, eerr, estr, lat, acc};
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(exp_q.size()), 32'(0));
    @(negedge clk);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct packed {
    logic        we;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic        full;
    logic        empty;
    logic [7:0]  rdata;
    logic        err;
    logic        strobe;
    int          lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int acc;
    int n_acc;
    int w;
    int snap;
    logic [10:0] a;

    for (int i = 0; i < 2048; i++) ctrl_mem[i] = 8'(i * 7 + 3);

    //          we    addr     wdata  full  empty rdata  err   strobe lat
    vecs[0] = '{1'b1, 11'h7FF, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5};
    vecs[1] = '{1'b0, 11'h7FF, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 5};
    vecs[2] = '{1'b1, 11'h040, 8'h11, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2};
    vecs[3] = '{1'b0, 11'h041, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 2};
    vecs[4] = '{1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 5};
    vecs[5] = '{1'b1, 11'h123, 8'h3C, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 5};
    vecs[6] = '{1'b0, 11'h123, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 5};

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    check("reset_rsp_we", 32'(rsp_we), 32'(0));
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'(0));
    check("reset_rsp_err", 32'(rsp_err), 32'(0));
    check("reset_seq_busy", 32'(seq_busy), 32'(0));
    check("reset_req_ready", 32'(req_ready), 32'(1));
    check("reset_strobes", 32'({mc_wr_req, mc_rd_req}), 32'(0));
    check("reset_mc_addr", 32'(mc_addr), 32'(0));
    check("reset_mc_data", 32'(mc_data_in), 32'(0));
    #2 rst = 1'b0;
    @(negedge clk);

    // Single requests from the table
    for (int i = 0; i < 7; i++) begin
      mc_full  = vecs[i].full;
      mc_empty = vecs[i].empty;
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err,
           vecs[i].strobe, vecs[i].lat, acc);
      drain();
      mc_full  = 1'b0;
      mc_empty = 1'b0;
    end

    // Busy stretch: 7 busy WAIT cycles add 7 cycles of latency
    mc_busy = 1'b1;
    send(1'b0, 11'h155, 8'h00, ctrl_mem[11'h155], 1'b0, 1'b1, 12, acc);
    while (cyc < acc + 11) @(negedge clk);
    mc_busy = 1'b0;
    drain();

    // Timeout: busy stuck, error with zero data at accept+69
    mc_busy = 1'b1;
    send(1'b0, 11'h2AA, 8'h00, 8'h00, 1'b1, 1'b1, 69, acc);
    drain();
    mc_busy = 1'b0;
    check("timeout_back_idle", 32'(seq_busy), 32'(0));

    // FIFO full / wrap, three rounds
    for (int wrap = 0; wrap < 3; wrap++) begin
      n_acc = 0;
      mc_busy = 1'b1;
      for (int k = 0; k < 8; k++) begin
        a = 11'($urandom_range(0, 2047));
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        req_wdata = 8'($urandom_range(0, 255));
        if (!req_ready) break;
        exp_q.push_back('{1'b0, a, req_wdata, ctrl_mem[a], 1'b0, 1'b1, -1, cyc});
        n_acc++;
        @(negedge clk);
      end
      check("fifo_accepted", 32'(n_acc), 32'(5));
      for (int k = 0; k < 3; k++) begin
        check("full_not_ready", 32'(req_ready), 32'(0));
        @(negedge clk);
      end
      req_valid = 1'b0;
      mc_busy = 1'b0;
      drain();
    end

    // Reset in the middle of ISSUE with three entries queued
    mc_busy = 1'b1;
    send(1'b0, 11'h010, 8'h00, ctrl_mem[11'h010], 1'b0, 1'b1, -1, acc);
    for (int k = 0; k < 4; k++) begin
      a = 11'($urandom_range(0, 2047));
      req_valid = 1'b1;
      req_we    = k[0];
      req_addr  = a;
      req_wdata = 8'($urandom_range(0, 255));
      check("rst_fill_ready", 32'(req_ready), 32'(1));
      exp_q.push_back('{k[0], a, req_wdata, k[0] ? 8'h00 : ctrl_mem[a], 1'b0, 1'b1, -1, cyc});
      @(negedge clk);
    end
    req_valid = 1'b0;
    mc_busy = 1'b0;
    w = 0;
    while (!(mc_wr_req || mc_rd_req) && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("rst_reached_issue", 32'(w < 50), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("rst_wr_drop", 32'(mc_wr_req), 32'(0));
    check("rst_rd_drop", 32'(mc_rd_req), 32'(0));
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'(1));
    check("rst_seq_busy", 32'(seq_busy), 32'(0));
    snap = rsp_seen;
    repeat (20) @(negedge clk);
    check("rst_no_rsp", 32'(rsp_seen - snap), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_request_sequencer.md
# mem_request_sequencer

Request front-end for the memory controller: accepts byte load/store requests from the core over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time on the controller's `wr_req`/`rd_req` strobes, honouring `busy`/`full`/`empty`, and returns one response per request. It sits directly upstream of the memory controller and owns all sequencing, hold timing and timeout handling for it.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `HOLD_CYCLES`, 2: cycles a controller strobe is held with address/data stable; ≥1.
- `TIMEOUT`, 64: maximum WAIT cycles with `mc_busy`=1 before an error response; ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  FIFO can accept: `!fifo_full`.
- `req_we`  in  1  1 = write (store), 0 = read (load).
- `req_addr`  in  11  byte address.
- `req_wdata`  in  8  store data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_we`  out  1  echo of the completed request's `req_we`.
- `rsp_rdata`  out  8  load data; 0 for writes and errors.
- `rsp_err`  out  1  request refused (full/empty) or timed out.
- `seq_busy`  out  1  FSM not IDLE or FIFO non-empty.
- `mc_wr_req`, `mc_rd_req`  out  1  controller strobes.
- `mc_addr`  out  11  controller address.
- `mc_data_in`  out  8  controller write data.
- `mc_data_out`  in  8  controller read data.
- `mc_busy`, `mc_full`, `mc_empty`  in  1  controller status.

## Operation
- FIFO entry: {we, addr[10:0], wdata[7:0]} = 20 bits. Push on `req_valid && req_ready`. `req_ready` is combinational from the occupancy count and ignores a same-cycle pop, so a full FIFO never accepts. Read/write pointers are log2(DEPTH) bits and wrap naturally; the count is log2(DEPTH)+1 bits.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if the FIFO is non-empty, pop the head into the command register. If (we && `mc_full`) or (!we && `mc_empty`), go to RESP with err=1 and issue no strobe. Otherwise go to ISSUE.
- ISSUE: assert `mc_wr_req` or `mc_rd_req` (never both), with `mc_addr`/`mc_data_in` from the command register, for exactly HOLD_CYCLES cycles. Then go to WAIT. A hold counter of width ≥ log2(HOLD_CYCLES)+1 controls the duration.
- WAIT: strobes are low and `mc_addr`/`mc_data_in` stay held.
  - Each cycle with `mc_busy`=0: capture `mc_data_out` (reads only) into the response register and go to RESP with err=0.
  - Each cycle with `mc_busy`=1: increment the timeout counter. When the counter reaches TIMEOUT, go to RESP with err=1 and rdata=0.
- RESP: `rsp_valid`=1 for one cycle, then IDLE. There is no response back-pressure; the core must accept every pulse.
- `mc_addr`/`mc_data_in` are 0 outside ISSUE/WAIT.
- Reset mid-operation: the in-flight request and all FIFO contents are discarded, no response is produced, and strobes drop immediately (asynchronously).

## Timing
- Reset values: `rsp_valid`, `rsp_we`, `rsp_rdata`, `rsp_err`, `seq_busy`, `mc_wr_req`, `mc_rd_req`, `mc_addr`, `mc_data_in` = 0. `req_ready`=1 (FIFO empty). FSM=IDLE, counters and pointers=0.
- Accept at cycle N into an empty FIFO with the FSM in IDLE:
  - pop at N+1;
  - strobe high N+2 … N+1+HOLD_CYCLES;
  - WAIT from N+2+HOLD_CYCLES;
  - with `mc_busy`=0, `rsp_valid` at N+3+HOLD_CYCLES (N+5 at default).
- Each cycle of `mc_busy`=1 in WAIT adds one cycle of latency. With `mc_busy` stuck at 1, the error response comes at N+3+HOLD_CYCLES+TIMEOUT.
- Refused request: `rsp_valid` with err=1 at N+2, and no strobe.
- Back-to-back throughput: one request per HOLD_CYCLES+3 cycles. The next pop happens in the IDLE cycle after RESP.
- Status inputs are sampled only in the states named above. `mc_full`/`mc_empty` changing during ISSUE/WAIT have no effect.

## Test plan
- Reset: assert `rst` mid-ISSUE with FIFO holding 3 entries → strobes 0 immediately; after release, `req_ready`=1, `seq_busy`=0, and no `rsp_valid` ever appears.
- Write then read: store 0xA5 @ 0x7FF, then load 0x7FF, with `mc_busy`=0 and the model returning 0xA5.
  - Required: `mc_wr_req` high exactly 2 cycles with addr 0x7FF and data 0xA5.
  - Required: the first `rsp_valid` comes 5 cycles after accept with we=1, err=0.
  - Required: the second response has rdata=0xA5.
- Busy stretch: `mc_busy` held 1 for 7 WAIT cycles → response 7 cycles later than nominal, err=0.
- Timeout: `mc_busy` stuck 1, TIMEOUT=64 → `rsp_err`=1, `rsp_rdata`=0 at accept+69, and the FSM returns to IDLE.
- Refusals: store with `mc_full`=1 → err response at accept+2, no `mc_wr_req`. Load with `mc_empty`=1 → same behaviour, no `mc_rd_req`.
- FIFO full/wrap: stall with `mc_busy`=1 and push until `req_ready`=0 → exactly 4 accepted (plus 1 in-flight).
  - Required: a `req_valid` while full is not accepted.
  - Required: after `mc_busy` releases, 5 responses arrive in order.
  - Repeat for 3 full wraps, checking addresses in order.
